lsu_unit: RTL
=============

Name: lsu_unit

Overview:
- Load/store unit directly downstream of the execute-stage ALU. It consumes the ALU result (`alu_out`) as the effective address and performs one RV32 load or store per request against a word-wide data memory, using a req/ack handshake.
- It generates byte enables, aligns store data, and sign- or zero-extends load data.
- The result goes to the writeback mux. `busy` stalls the pipeline while an access is outstanding.

Parameters:
- WIDTH, 32, datapath and address width; only 32 is supported (byte enables are fixed at 4 bits).
- TIMEOUT, 16, max cycles `mem_req` is held without `mem_ack` before `fault`; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  WIDTH  effective address, driven from `alu_out`
- wdata  input  WIDTH  store data (rs2), right-justified
- busy  output  1  access in progress
- done  output  1  one-cycle completion pulse
- rdata_out  output  WIDTH  extended load result
- fault  output  1  misaligned, illegal funct3, or timeout; valid while `done`=1
- mem_req  output  1  memory request
- mem_we  output  1  memory write enable
- mem_addr  output  WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_be  output  4  byte enables
- mem_wdata  output  WIDTH  lane-aligned store data
- mem_rdata  input  WIDTH  read data; valid when `mem_ack`=1
- mem_ack  input  1  memory acknowledge

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-access drops `mem_req` at the same edge; no `done` is produced.
- States: IDLE, REQ, (REQ_HI), RESP.
- IDLE:
  - `start`=1 latches is_store, funct3, addr and wdata.
  - Illegal funct3 (011, 110, 111, or a store with 1xx) or a misaligned address goes to RESP with `fault`=1 and issues no memory request.
  - Misaligned means: H with addr[0]=1; W with addr[1:0]≠0.
  - Otherwise go to REQ.
- REQ:
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and stay stable until ack.
  - On `mem_ack`=1: capture the extended load data and go to RESP.
  - The timeout counter increments on each REQ cycle without ack. At TIMEOUT it goes to RESP with `fault`=1.
- RESP: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in REQ, REQ_HI and RESP. `start` is ignored while busy.
- Latency: `start` at cycle n gives `mem_req` at n+1. Ack at cycle n+k gives `done` at n+k+1. The minimum is 2 cycles.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<addr[1:0]
  - W: 1111
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word as is.
- Load extract: lane = addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Store completion: `rdata_out` = 0 on `done`.
- `rdata_out` holds its value until the next `done`.
- Faulted completion: `rdata_out` = 0.
- `mem_ack` is ignored outside REQ and REQ_HI.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - A misaligned H (addr[1:0]=11) or misaligned W is split into two accesses.
  - First access: REQ at word `addr`, using the low-part byte enables.
  - Second access: REQ_HI at `mem_addr`+4, which wraps modulo 2^WIDTH, using the remaining byte enables.
  - The bytes are merged before extension. `fault` is reported only for illegal funct3 or a timeout in either phase.
  - The timeout counter resets between the two phases.
  - H at addr[1:0]=01 stays a single access.
- Undefined: REQ_HI is absent and misaligned accesses fault as described above.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding
  - BE width constant 4
- Sub-module lsu_align (combinational), containing:
  - `be` generation
  - store lane replication
  - load byte extraction and extension
  - the split merge path when the macro is defined
- The FSM, handshake and timeout logic stay in lsu_unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack 2 cycles after req → `mem_be`=1111, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `done` exactly 1 cycle, `fault`=0.
- SB addr=0x103, wdata=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x100.
- LB addr=0x202, `mem_rdata`=0x11802233 → `rdata_out`=0xFFFFFF80; LBU at the same address → 0x00000080; LHU addr=0x202 → 0x00001180.
- LW addr=0x102 → no `mem_req`, `done` 2 cycles after `start`, `fault`=1. With the macro: two reqs at 0x100 then 0x104, `rdata` 0xAABB0000 then 0x0000CCDD → 0xCCDDAABB.
- Load with `mem_ack` never asserted, TIMEOUT=16 → `mem_req` high 16 cycles, then `done` with `fault`=1. Reset asserted mid-REQ → next cycle `mem_req`=0, `busy`=0, no `done`.
- `start` pulsed while `busy`, and `mem_ack` pulsed in IDLE → both ignored; the original access completes once.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, funct3 codes and FSM state encoding for the load/store unit
package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_REQ_HI = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Encodings with no RV32 meaning, plus unsigned stores.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic st);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (st && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-enable, store-lane and load-extract datapath
//
// Ports: funct3/offset select access size and byte lane; wdata is right-justified
// store data, wdata_out the lane-aligned copy; be_lo the byte enables of the
// (first) word; rdata_lo the word read (first word when split), rdata_ext the
// extended load result. With LSU_MISALIGNED_SPLIT_EN: rdata_hi is the second
// word of a split access and be_hi its byte enables (zero when no split needed).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [31:0]     wdata,
    input  logic [31:0]     rdata_lo,
`ifdef LSU_MISALIGNED_SPLIT_EN
    input  logic [31:0]     rdata_hi,
    output logic [BE_W-1:0] be_hi,
`endif
    output logic [BE_W-1:0] be_lo,
    output logic [31:0]     wdata_out,
    output logic [31:0]     rdata_ext
);

    logic [BE_W-1:0] be_base;
    logic [31:0]     rep;
    logic [31:0]     lane;
    logic [4:0]      shamt;

    assign shamt = {offset, 3'b000};

    always_comb begin
        case (funct3[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign be_lo = be_base << offset;
`ifdef LSU_MISALIGNED_SPLIT_EN
    // Lanes pushed past byte 3 land at the bottom of the next word.
    assign be_hi = be_base >> (3'd4 - {1'b0, offset});
`endif

    always_comb begin
        case (funct3[1:0])
            2'b00:   rep = {4{wdata[7:0]}};
            2'b01:   rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
    end

    // Rotating the replicated data leaves aligned accesses unchanged and puts
    // every byte of an in-word or split access on the lane its enable selects;
    // both words of a split store use this same rotated value.
    always_comb begin
        case (offset)
            2'd0:    wdata_out = rep;
            2'd1:    wdata_out = {rep[23:0], rep[31:24]};
            2'd2:    wdata_out = {rep[15:0], rep[31:16]};
            default: wdata_out = {rep[7:0],  rep[31:8]};
        endcase
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [63:0] pair;
    assign pair = {rdata_hi, rdata_lo};
    assign lane = 32'(pair >> shamt);
`else
    assign lane = rdata_lo >> shamt;
`endif

    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_ext = {{16{lane[15]}}, lane[15:0]};
            F3_W:    rdata_ext = lane;
            F3_BU:   rdata_ext = {24'b0, lane[7:0]};
            F3_HU:   rdata_ext = {16'b0, lane[15:0]};
            default: rdata_ext = 32'b0;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - RV32 load/store unit: request FSM, memory handshake and timeout
//
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (split misaligned H/W into two accesses).
// Ports: clk, reset (sync, active-high); start/is_store/funct3/addr/wdata request
// from execute; busy/done/rdata_out/fault back to the pipeline; mem_req/mem_we/
// mem_addr/mem_be/mem_wdata/mem_rdata/mem_ack word-wide data memory handshake.
module lsu_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata_out,
    output logic             fault,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [BE_W-1:0]  mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] tcnt;

    logic [2:0]      a_f3;
    logic [1:0]      a_off;
    logic [BE_W-1:0] be_lo;
    logic [31:0]     wd_al;
    logic [31:0]     rd_ext;
    logic            illegal;
    logic            misal;
    logic            bad;

    // In IDLE the aligner sees the incoming request so the memory-side
    // registers can be loaded on the start edge; afterwards it sees the latch.
    assign a_f3  = (state == S_IDLE) ? funct3    : f3_q;
    assign a_off = (state == S_IDLE) ? addr[1:0] : off_q;

    assign illegal = f3_illegal(funct3, is_store);
    assign misal   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic            split_q;
    logic [31:0]     lo_q;
    logic [BE_W-1:0] be_hi;
    logic [31:0]     rd_lo;

    assign bad   = illegal;
    assign rd_lo = (state == S_REQ_HI) ? lo_q : mem_rdata;

    lsu_align u_align (
        .funct3    (a_f3),
        .offset    (a_off),
        .wdata     (wdata),
        .rdata_lo  (rd_lo),
        .rdata_hi  (mem_rdata),
        .be_hi     (be_hi),
        .be_lo     (be_lo),
        .wdata_out (wd_al),
        .rdata_ext (rd_ext)
    );
`else
    assign bad = illegal || misal;

    lsu_align u_align (
        .funct3    (a_f3),
        .offset    (a_off),
        .wdata     (wdata),
        .rdata_lo  (mem_rdata),
        .be_lo     (be_lo),
        .wdata_out (wd_al),
        .rdata_ext (rd_ext)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            st_q      <= 1'b0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            tcnt      <= 32'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata_out <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q   <= 1'b0;
            lo_q      <= 32'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        st_q  <= is_store;
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        tcnt  <= 32'b0;
                        busy  <= 1'b1;
                        if (bad) begin
                            // done stays low for this first RESP cycle.
                            fault <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            fault     <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                            mem_be    <= be_lo;
                            mem_wdata <= wd_al;
`ifdef LSU_MISALIGNED_SPLIT_EN
                            split_q   <= (be_hi != '0);
`endif
                            state     <= S_REQ;
                        end
                    end
                end

                S_REQ, S_REQ_HI: begin
                    if (mem_ack) begin
                        tcnt <= 32'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (state == S_REQ && split_q) begin
                            lo_q     <= mem_rdata;
                            mem_addr <= mem_addr + WIDTH'(4);
                            mem_be   <= be_hi;
                            state    <= S_REQ_HI;
                        end else
`endif
                        begin
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            done      <= 1'b1;
                            rdata_out <= st_q ? '0 : rd_ext;
                            state     <= S_RESP;
                        end
                    end else if (TIMEOUT != 0 && tcnt == TO_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        fault     <= 1'b1;
                        rdata_out <= '0;
                        state     <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end

                S_RESP: begin
                    if (!done) begin
                        // Request rejected in IDLE: raise done one cycle late so
                        // it keeps the same two-cycle minimum as a real access.
                        done      <= 1'b1;
                        rdata_out <= '0;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        fault <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
